// File: rtl/normalize.sv
// normalize: shifts an operand left by a supplied leading-zero count so the
// MSB lands in bit 31, producing the matching exponent and a zero flag.
// The shift is spread over several cycles, at most STEP bits per clock.
module normalize #(
   parameter int unsigned STEP = 8
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        start,
   input  logic [31:0] a,
   input  logic [31:0] lz,
   output logic        busy,
   output logic        done,
   output logic [31:0] result,
   output logic [5:0]  exp,
   output logic        zero
);

   localparam int unsigned DATA_W = 32;
   localparam int unsigned CNT_W  = 6;
   localparam logic [CNT_W-1:0] STEP_AMT = CNT_W'(STEP);
   localparam logic [CNT_W-1:0] MSB_POS  = CNT_W'(DATA_W - 1);
   localparam logic [CNT_W-1:0] ZERO_LZ  = CNT_W'(DATA_W);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      DONE  = 2'd2
   } state_t;

   state_t              state;
   state_t              state_next;
   logic [DATA_W-1:0]   w;
   logic [DATA_W-1:0]   w_next;
   logic [CNT_W-1:0]    r;
   logic [CNT_W-1:0]    r_next;
   logic [CNT_W-1:0]    exp_next;
   logic                zero_next;
   logic [CNT_W-1:0]    amt;
   logic [CNT_W-1:0]    lz_lo;
   logic                unused_lz;

   // Only the low six bits of the count matter; upper bits are don't-care.
   assign lz_lo     = lz[CNT_W-1:0];
   assign unused_lz = ^lz[DATA_W-1:CNT_W];

   // The working register is the result, visible at all times.
   assign result = w;

   // Next-state and datapath: load in IDLE, shift by min(R, STEP) in SHIFT.
   always_comb begin
      state_next = state;
      w_next     = w;
      r_next     = r;
      exp_next   = exp;
      zero_next  = zero;
      amt        = (r < STEP_AMT) ? r : STEP_AMT;

      case (state)
         IDLE: begin
            if (start) begin
               if (lz_lo >= ZERO_LZ) begin
                  w_next     = '0;
                  r_next     = '0;
                  exp_next   = '0;
                  zero_next  = 1'b1;
                  state_next = DONE;
               end else begin
                  w_next     = a;
                  r_next     = lz_lo;
                  exp_next   = MSB_POS - lz_lo;
                  zero_next  = 1'b0;
                  state_next = (lz_lo == '0) ? DONE : SHIFT;
               end
            end
         end
         SHIFT: begin
            w_next = w << amt;
            r_next = r - amt;
            if (r == amt) begin
               state_next = DONE;
            end
         end
         DONE: begin
            state_next = IDLE;
         end
         default: begin
            state_next = IDLE;
         end
      endcase
   end

   // State, datapath and status flags; busy/done follow the next state so
   // they line up with the state register.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state <= IDLE;
         w     <= '0;
         r     <= '0;
         exp   <= '0;
         zero  <= 1'b0;
         busy  <= 1'b0;
         done  <= 1'b0;
      end else begin
         state <= state_next;
         w     <= w_next;
         r     <= r_next;
         exp   <= exp_next;
         zero  <= zero_next;
         busy  <= (state_next != IDLE);
         done  <= (state_next == DONE);
      end
   end

endmodule

// File: tb/tb_normalize.sv
// tb_normalize: directed and swept checks of the multi-cycle normalizer.
module tb_normalize;

   localparam int unsigned STEP = 8;

   logic        clk;
   logic        reset;
   logic        start;
   logic [31:0] a;
   logic [31:0] lz;
   logic        busy;
   logic        done;
   logic [31:0] result;
   logic [5:0]  exp;
   logic        zero;

   int n_checks;
   int n_pass;

   normalize #(.STEP(STEP)) dut (
      .clk    (clk),
      .reset  (reset),
      .start  (start),
      .a      (a),
      .lz     (lz),
      .busy   (busy),
      .done   (done),
      .result (result),
      .exp    (exp),
      .zero   (zero)
   );

   // Free-running clock.
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Single comparison point: count and report.
   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
      n_checks++;
      if (got === want) begin
         n_pass++;
      end else begin
         $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, want);
      end
   endtask

   function automatic int clz_ref(input logic [31:0] v);
      int n;
      n = 32;
      for (int i = 31; i >= 0; i--) begin
         if (v[i]) begin
            n = 31 - i;
            break;
         end
      end
      return n;
   endfunction

   // Launch one operation, wait for done, check against a reference model.
   task automatic run_op(input logic [31:0] av, input logic [31:0] lzv,
                         input bit noise, input string tag,
                         output logic [31:0] res_o);
      int          lat;
      int          busy_cnt;
      int          l6;
      int          want_lat;
      logic [31:0] want_res;
      logic [31:0] want_exp;
      logic        want_zero;

      l6 = int'(lzv[5:0]);
      if (l6 >= 32) begin
         want_res  = '0;
         want_exp  = '0;
         want_zero = 1'b1;
         want_lat  = 1;
      end else begin
         want_res  = av << l6;
         want_exp  = 32'(31 - l6);
         want_zero = 1'b0;
         want_lat  = (l6 == 0) ? 1 : 1 + (l6 + int'(STEP) - 1) / int'(STEP);
      end

      @(negedge clk);
      start = 1'b1;
      a     = av;
      lz    = lzv;
      @(posedge clk);
      @(negedge clk);
      start    = 1'b0;
      lat      = 1;
      busy_cnt = 0;
      while (1) begin
         if (busy) busy_cnt++;
         if (done || lat >= 200) break;
         if (noise) begin
            start = 1'b1;
            a     = $urandom;
            lz    = $urandom_range(0, 63);
         end
         @(posedge clk);
         @(negedge clk);
         lat++;
      end
      start = 1'b0;

      chk({tag, " done seen"}, 32'(done), 32'd1);
      chk({tag, " latency"}, 32'(lat), 32'(want_lat));
      chk({tag, " busy cycles"}, 32'(busy_cnt), 32'(want_lat));
      chk({tag, " result"}, result, want_res);
      chk({tag, " exp"}, 32'(exp), want_exp);
      chk({tag, " zero"}, 32'(zero), 32'(want_zero));
      res_o = result;

      @(negedge clk);
      chk({tag, " done pulse width"}, 32'({busy, done}), 32'd0);
      chk({tag, " result hold"}, result, want_res);
   endtask

   initial begin
      logic [31:0] res;
      logic [31:0] rv;
      int          done_seen;

      n_checks = 0;
      n_pass   = 0;
      reset    = 1'b1;
      start    = 1'b0;
      a        = '0;
      lz       = '0;

      #1;
      chk("reset state", {22'd0, busy, done, exp, zero, 1'b0}, 32'd0);
      chk("reset result", result, 32'd0);
      @(negedge clk);
      @(negedge clk);
      reset = 1'b0;

      // Typical two-step shift.
      run_op(32'h0001_2345, 32'd15, 1'b0, "lz15", res);
      chk("lz15 const result", res, 32'h91A2_8000);
      chk("lz15 const exp", 32'(exp), 32'd16);

      // Already normalized: straight to DONE.
      run_op(32'h8000_0000, 32'd0, 1'b0, "lz0", res);
      chk("lz0 const exp", 32'(exp), 32'd31);

      // Zero operand.
      run_op(32'h0000_0000, 32'd32, 1'b0, "lz32", res);
      chk("lz32 const zero", 32'(zero), 32'd1);

      // lz 63 is also a zero operand; upper lz bits ignored.
      run_op(32'h1234_5678, 32'd63, 1'b0, "lz63", res);
      run_op(32'h00AB_0000, 32'hFFFF_FFC8, 1'b0, "lzhi", res);
      chk("lzhi const result", res, 32'hAB00_0000);

      // Full 31-bit shift with start noise while busy.
      run_op(32'h0000_0001, 32'd31, 1'b1, "lz31 noise", res);
      chk("lz31 const result", res, 32'h8000_0000);
      chk("lz31 const exp", 32'(exp), 32'd0);

      // Reset mid-shift aborts immediately, no done afterwards.
      @(negedge clk);
      start = 1'b1;
      a     = 32'h0000_0001;
      lz    = 32'd31;
      @(posedge clk);
      @(negedge clk);
      start = 1'b0;
      @(posedge clk);
      #2 reset = 1'b1;
      #1;
      chk("async reset flags", {26'd0, busy, done, exp[3:0]}, 32'd0);
      chk("async reset result", result, 32'd0);
      chk("async reset exp zero", {25'd0, exp, zero}, 32'd0);
      @(negedge clk);
      reset     = 1'b0;
      done_seen = 0;
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         if (done || busy) done_seen++;
      end
      chk("no done after abort", 32'(done_seen), 32'd0);
      run_op(32'h00F0_0000, 32'd8, 1'b0, "post reset", res);
      chk("post reset const", res, 32'hF000_0000);
      chk("post reset const exp", 32'(exp), 32'd23);

      // start held high: DONE, IDLE, then the next op is accepted.
      @(negedge clk);
      start = 1'b1;
      a     = 32'h8000_0000;
      lz    = 32'd0;
      @(posedge clk);
      @(negedge clk);
      chk("b2b done 1", 32'(done), 32'd1);
      a  = 32'h0F00_0000;
      lz = 32'd4;
      @(posedge clk);
      @(negedge clk);
      chk("b2b idle gap", 32'({busy, done}), 32'd0);
      @(posedge clk);
      @(negedge clk);
      chk("b2b accepted", 32'({busy, done}), 32'd2);
      start = 1'b0;
      @(posedge clk);
      @(negedge clk);
      chk("b2b done 2", 32'(done), 32'd1);
      chk("b2b result", result, 32'hF000_0000);
      chk("b2b exp", 32'(exp), 32'd27);

      // Random sweep with clz-reference counts.
      for (int k = 0; k < 24; k++) begin
         rv = $urandom >> $urandom_range(0, 31);
         if (rv == 0) rv = 32'h1;
         run_op(rv, 32'(clz_ref(rv)), 1'(k % 2), "sweep", res);
         chk("sweep msb", 32'(res[31]), 32'd1);
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
